game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_game_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl - pinball-style game sequencer.
//
// Walks a game through RESET -> WAIT -> START -> GET -> (WAIT | OVER).
// In WAIT the active scoring group rotates every DWELL cycles; a start-button
// edge launches a ball, which is caught in START (or times out), shown in GET
// for SHOW cycles, and the game ends in OVER when the scorer reports a win or
// the last ball has been played.
//
// Optional feature: define GROUP_RANDOM_EN to pick the scoring group from an
// 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) instead of stepping it
// sequentially. The default build (macro undefined) has no LFSR logic.

module game_ctrl #(
    parameter int BALLS        = 5,
    parameter int DWELL        = 16,
    parameter int BALL_TIMEOUT = 64,
    parameter int SHOW         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic [7:0] ball,
    input  logic       win,
    output logic [2:0] state,
    output logic [2:0] selected_group,
    output logic [3:0] balls_left,
    output logic       launch,
    output logic [7:0] last_hole,
    output logic       lost
);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_WAIT  = 3'd1,
        S_START = 3'd2,
        S_GET   = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    // Counter widths are sized to hold the terminal count itself.
    localparam int DW_W = $clog2(DWELL + 1);
    localparam int TO_W = $clog2(BALL_TIMEOUT + 1);
    localparam int SH_W = $clog2(SHOW + 1);

    localparam logic [DW_W-1:0] DW_LAST  = DW_W'(DWELL - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(BALL_TIMEOUT - 1);
    localparam logic [SH_W-1:0] SH_LAST  = SH_W'(SHOW - 1);
    localparam logic [DW_W-1:0] DW_ONE   = DW_W'(1'b1);
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1'b1);
    localparam logic [SH_W-1:0] SH_ONE   = SH_W'(1'b1);
    localparam logic [3:0]      BALLS_L  = 4'(BALLS);

`ifdef GROUP_RANDOM_EN
    localparam logic [7:0]      LFSR_SEED = 8'hA5;

    // One Fibonacci step: taps 8,6,5,4 feed back into bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction
`else
    // Sequential rotation through the eight groups; 7 wraps to 0.
    function automatic logic [2:0] group_step(input logic [2:0] g);
        return g + 3'd1;
    endfunction
`endif

    state_t            r_state;
    state_t            w_next_state;

    logic              r_btn_prev;
    logic              w_start_edge;

    logic [DW_W-1:0]   r_dwell;
    logic [DW_W-1:0]   w_dwell_next;
    logic [TO_W-1:0]   r_tmo;
    logic [TO_W-1:0]   w_tmo_next;
    logic [SH_W-1:0]   r_show;
    logic [SH_W-1:0]   w_show_next;

    logic [2:0]        r_group;
    logic [2:0]        w_group_next;
    logic [3:0]        r_balls;
    logic [3:0]        w_balls_next;
    logic              r_launch;
    logic              w_launch_next;
    logic [7:0]        r_last_hole;
    logic [7:0]        w_last_hole_next;
    logic              r_lost;
    logic              w_lost_next;

`ifdef GROUP_RANDOM_EN
    logic [7:0]        r_lfsr;
    logic [7:0]        w_lfsr_next;
    logic [7:0]        w_lfsr_stepped;

    assign w_lfsr_stepped = lfsr_step(r_lfsr);
`endif

    // A held button yields a single edge: compare against last cycle's level.
    assign w_start_edge = start_btn & ~r_btn_prev;

    // Previous start-button level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_prev <= 1'b0;
        end else begin
            r_btn_prev <= start_btn;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and next-value logic for every registered output and counter.
    always_comb begin
        w_next_state     = r_state;
        w_dwell_next     = '0;
        w_tmo_next       = '0;
        w_show_next      = '0;
        w_group_next     = r_group;
        w_balls_next     = r_balls;
        w_launch_next    = 1'b0;
        w_last_hole_next = r_last_hole;
        w_lost_next      = r_lost;
`ifdef GROUP_RANDOM_EN
        w_lfsr_next      = r_lfsr;
`endif

        case (r_state)
            S_RESET: begin
                w_next_state     = S_WAIT;
                w_balls_next     = BALLS_L;
                w_group_next     = 3'd0;
                w_last_hole_next = 8'h00;
                w_lost_next      = 1'b0;
            end

            S_WAIT: begin
                if (w_start_edge && (r_balls != 4'd0)) begin
                    // Launch: the group freezes here until GET exits.
                    w_next_state     = S_START;
                    w_balls_next     = r_balls - 4'd1;
                    w_launch_next    = 1'b1;
                    w_last_hole_next = 8'h00;
                    w_lost_next      = 1'b0;
                end else if (r_dwell >= DW_LAST) begin
                    w_dwell_next = '0;
`ifdef GROUP_RANDOM_EN
                    w_lfsr_next  = w_lfsr_stepped;
                    w_group_next = w_lfsr_stepped[2:0];
`else
                    w_group_next = group_step(r_group);
`endif
                end else begin
                    w_dwell_next = r_dwell + DW_ONE;
                end
            end

            S_START: begin
                if (ball != 8'h00) begin
                    // Capture the vector as-is, even with several bits set.
                    w_next_state     = S_GET;
                    w_last_hole_next = ball;
                end else if (r_tmo >= TO_LAST) begin
                    w_next_state     = S_GET;
                    w_lost_next      = 1'b1;
                    w_last_hole_next = 8'h00;
                end else begin
                    w_tmo_next = r_tmo + TO_ONE;
                end
            end

            S_GET: begin
                if (r_show >= SH_LAST) begin
                    // lost only describes the ball being shown.
                    w_lost_next = 1'b0;
                    if (win || (r_balls == 4'd0)) begin
                        w_next_state = S_OVER;
                    end else begin
                        w_next_state = S_WAIT;
                    end
                end else begin
                    w_show_next = r_show + SH_ONE;
                end
            end

            S_OVER: begin
                if (w_start_edge) begin
                    // Present reset values for the whole RESET cycle.
                    w_next_state     = S_RESET;
                    w_balls_next     = BALLS_L;
                    w_group_next     = 3'd0;
                    w_last_hole_next = 8'h00;
                    w_lost_next      = 1'b0;
                end else begin
                    w_next_state = S_OVER;
                end
            end

            default: begin
                // Unused encodings fall back to RESET, which reloads everything.
                w_next_state = S_RESET;
            end
        endcase
    end

    // Counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell     <= '0;
            r_tmo       <= '0;
            r_show      <= '0;
            r_group     <= 3'd0;
            r_balls     <= BALLS_L;
            r_launch    <= 1'b0;
            r_last_hole <= 8'h00;
            r_lost      <= 1'b0;
        end else begin
            r_dwell     <= w_dwell_next;
            r_tmo       <= w_tmo_next;
            r_show      <= w_show_next;
            r_group     <= w_group_next;
            r_balls     <= w_balls_next;
            r_launch    <= w_launch_next;
            r_last_hole <= w_last_hole_next;
            r_lost      <= w_lost_next;
        end
    end

`ifdef GROUP_RANDOM_EN
    // Random group source, stepped once per dwell period in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end
`endif

    assign state          = r_state;
    assign selected_group = r_group;
    assign balls_left     = r_balls;
    assign launch         = r_launch;
    assign last_hole      = r_last_hole;
    assign lost           = r_lost;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl with default parameters.
module tb_game_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start_btn;
    logic [7:0] ball;
    logic       win;
    logic [2:0] state;
    logic [2:0] selected_group;
    logic [3:0] balls_left;
    logic       launch;
    logic [7:0] last_hole;
    logic       lost;

    int n_cmp;
    int n_err;

    game_ctrl #(
        .BALLS(5), .DWELL(16), .BALL_TIMEOUT(64), .SHOW(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .ball(ball),
        .win(win), .state(state), .selected_group(selected_group),
        .balls_left(balls_left), .launch(launch), .last_hole(last_hole),
        .lost(lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Launch one ball from WAIT, catch it with hole vector b, ride out GET.
    task automatic play_ball(input logic [7:0] b, input logic w,
                             input logic [3:0] exp_balls, input logic [2:0] exp_after);
        start_btn = 1'b1;
        tick();
        check("pb_start_state", state, 3'd2);
        check("pb_launch", launch, 1'b1);
        check("pb_balls", balls_left, exp_balls);
        start_btn = 1'b0;
        ball = b;
        tick();
        check("pb_get_state", state, 3'd3);
        check("pb_last_hole", last_hole, b);
        ball = 8'h00;
        win  = w;
        repeat (7) tick();
        check("pb_get_last", state, 3'd3);
        tick();
        win = 1'b0;
        check("pb_after_state", state, exp_after);
    endtask

    initial begin
        logic [7:0] hole;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start_btn = 1'b0;
        ball = 8'h00;
        win = 1'b0;

        // Reset values while rst_n is held low.
        repeat (2) @(negedge clk);
        check("rst_state", state, 3'd0);
        check("rst_group", selected_group, 3'd0);
        check("rst_balls", balls_left, 4'd5);
        check("rst_launch", launch, 1'b0);
        check("rst_hole", last_hole, 8'h00);
        check("rst_lost", lost, 1'b0);
        rst_n = 1'b1;
        check("rel_state_reset", state, 3'd0);
        tick();

        // Group rotation: 0 for 16 cycles, then 1, then 2 at cycle 32.
        for (int k = 0; k < 40; k++) begin
            check("wait_state", state, 3'd1);
            check("wait_group", selected_group, 3'(k / 16));
            tick();
        end

        // Launch a ball, catch it in hole 2; start edge in GET is ignored.
        start_btn = 1'b1;
        tick();
        check("l_state", state, 3'd2);
        check("l_launch", launch, 1'b1);
        check("l_balls", balls_left, 4'd4);
        check("l_group", selected_group, 3'd2);
        start_btn = 1'b0;
        tick();
        check("l_launch_once", launch, 1'b0);
        check("l_state2", state, 3'd2);
        tick();
        check("l_state3", state, 3'd2);
        ball = 8'h04;
        tick();
        ball = 8'h00;
        check("g_state", state, 3'd3);
        check("g_hole", last_hole, 8'h04);
        check("g_lost", lost, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("g_hold_state", state, 3'd3);
            check("g_hold_group", selected_group, 3'd2);
            if (i == 2) start_btn = 1'b1;
            else if (i == 4) start_btn = 1'b0;
            else start_btn = start_btn;
        end
        tick();
        check("g_exit_state", state, 3'd1);
        check("g_exit_group", selected_group, 3'd2);
        check("g_exit_balls", balls_left, 4'd4);

        // Ball ignored in WAIT.
        ball = 8'h10;
        repeat (5) tick();
        check("w_ign_hole", last_hole, 8'h04);
        check("w_ign_state", state, 3'd1);
        ball = 8'h00;

        // Timeout: 64 cycles in START with no ball.
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        check("to_balls", balls_left, 4'd3);
        for (int i = 1; i < 64; i++) begin
            tick();
            check("to_start", state, 3'd2);
        end
        tick();
        check("to_get", state, 3'd3);
        check("to_lost", lost, 1'b1);
        check("to_hole", last_hole, 8'h00);
        repeat (7) tick();
        check("to_lost_hold", lost, 1'b1);
        tick();
        check("to_wait", state, 3'd1);
        check("to_lost_clr", lost, 1'b0);

        // Win in GET -> OVER; multi-bit capture; OVER holds; restart.
        play_ball(8'h81, 1'b1, 4'd2, 3'd4);
        ball = 8'h40;
        repeat (3) tick();
        ball = 8'h00;
        check("ov_state", state, 3'd4);
        check("ov_hole", last_hole, 8'h81);
        check("ov_balls", balls_left, 4'd2);
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        check("rs_state", state, 3'd0);
        check("rs_balls", balls_left, 4'd5);
        tick();
        check("rs_wait", state, 3'd1);
        check("rs_wait_balls", balls_left, 4'd5);
        check("rs_group", selected_group, 3'd0);

        // Five balls, no win -> OVER when balls run out.
        hole = 8'h01;
        for (int i = 0; i < 5; i++) begin
            play_ball(hole, 1'b0, 4'(4 - i), (i == 4) ? 3'd4 : 3'd1);
            hole = hole << 1;
        end
        check("end_balls", balls_left, 4'd0);

        // Held button: one OVER->RESET transition only.
        start_btn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("held_state", state, (c == 0) ? 3'd0 : 3'd1);
        end
        check("held_launch", launch, 1'b0);
        check("held_balls", balls_left, 4'd5);
        start_btn = 1'b0;
        tick();

        // Asynchronous reset in the middle of START.
        start_btn = 1'b1;
        tick();
        check("ar_pre_state", state, 3'd2);
        check("ar_pre_launch", launch, 1'b1);
        start_btn = 1'b0;
        ball = 8'h80;
        rst_n = 1'b0;
        #1;
        check("ar_state", state, 3'd0);
        check("ar_launch", launch, 1'b0);
        check("ar_balls", balls_left, 4'd5);
        check("ar_hole", last_hole, 8'h00);
        check("ar_lost", lost, 1'b0);
        check("ar_group", selected_group, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("ar_wait_state", state, 3'd1);
            check("ar_wait_hole", last_hole, 8'h00);
            tick();
        end
        check("ar_wait_balls", balls_left, 4'd5);
        ball = 8'h00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
